// File: rtl/trigger_pkg.sv
// Shared types and default widths for the trigger pulse generator.
package trigger_pkg;
  localparam int DEF_OFFSET_W = 32;
  localparam int DEF_WIDTH_W  = 16;
  localparam int DEF_COUNT_W  = 8;

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} trig_state_e;
endpackage

// File: rtl/trigger_downcount.sv
// Loadable down-counter; o_tc flags a current value of exactly 1.
module trigger_downcount #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val,
  output logic         o_tc
);
  logic [W-1:0] r_val;

  always_ff @(posedge clk) begin
    if (reset)       r_val <= '0;
    else if (i_load) r_val <= i_val;
    else if (i_en)   r_val <= r_val - 1'b1;
  end

  assign o_val = r_val;
  assign o_tc  = (r_val == W'(1));
endmodule

// File: rtl/trigger_pulse_gen.sv
// Offset-delayed trigger pulse / pulse-train generator with registered outputs.
// TRIGGER_PULSE_GEN_REPEAT_EN enables multi-pulse trains (gap and count honoured).
module trigger_pulse_gen
  import trigger_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int WIDTH_W  = DEF_WIDTH_W,
  parameter int COUNT_W  = DEF_COUNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [WIDTH_W-1:0]  width,
  input  logic [WIDTH_W-1:0]  gap,
  input  logic [COUNT_W-1:0]  count,
  output logic                exttrig_out,
  output logic                busy,
  output logic                done
);
  trig_state_e        r_state;
  logic               r_exttrig, r_busy, r_done;
  logic [WIDTH_W-1:0] r_width;

  logic               w_accept, w_last;
  logic [WIDTH_W-1:0] w_width_in;
  logic               w_dly_load, w_dly_en, w_dly_tc;
  logic [OFFSET_W-1:0] w_dly_val;
  logic               w_pw_load, w_pw_en, w_pw_tc;
  logic [WIDTH_W-1:0] w_pw_ld_val, w_pw_val;

  assign w_accept   = (r_state == IDLE) && start && !abort;
  assign w_width_in = (width == '0) ? WIDTH_W'(1) : width;

`ifdef TRIGGER_PULSE_GEN_REPEAT_EN
  logic [WIDTH_W-1:0] r_gap;
  logic [COUNT_W-1:0] w_cnt_val;
  logic               w_cnt_tc;

  // Remaining-pulse counter: loaded at accept, stepped at the end of each HIGH.
  trigger_downcount #(.W(COUNT_W)) u_cnt (
    .clk(clk), .reset(reset),
    .i_load(w_accept),
    .i_en((r_state == HIGH) && w_pw_tc),
    .i_val((count == '0) ? COUNT_W'(1) : count),
    .o_val(w_cnt_val), .o_tc(w_cnt_tc)
  );
  assign w_last = w_cnt_tc;
`else
  logic w_unused;
  assign w_unused = ^{gap, count};
  assign w_last   = 1'b1;
`endif

  always_comb begin
    w_dly_load  = w_accept && (offset != '0);
    w_dly_val   = offset;
    w_dly_en    = (r_state == DELAY);
    w_pw_load   = 1'b0;
    w_pw_ld_val = r_width;
    w_pw_en     = (r_state == HIGH) || (r_state == GAP);
    if (w_accept && (offset == '0)) begin
      w_pw_load   = 1'b1;
      w_pw_ld_val = w_width_in;
    end else if ((r_state == DELAY) && w_dly_tc) begin
      w_pw_load = 1'b1;
    end else if ((r_state == GAP) && w_pw_tc) begin
      w_pw_load = 1'b1;
`ifdef TRIGGER_PULSE_GEN_REPEAT_EN
    end else if ((r_state == HIGH) && w_pw_tc && !w_last) begin
      w_pw_load   = 1'b1;
      w_pw_ld_val = r_gap;
`endif
    end
  end

  trigger_downcount #(.W(OFFSET_W)) u_dly (
    .clk(clk), .reset(reset),
    .i_load(w_dly_load), .i_en(w_dly_en), .i_val(w_dly_val),
    .o_val(), .o_tc(w_dly_tc)
  );

  // Shared between pulse-high and inter-pulse gap timing.
  trigger_downcount #(.W(WIDTH_W)) u_pw (
    .clk(clk), .reset(reset),
    .i_load(w_pw_load), .i_en(w_pw_en), .i_val(w_pw_ld_val),
    .o_val(w_pw_val), .o_tc(w_pw_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_exttrig <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_width   <= '0;
`ifdef TRIGGER_PULSE_GEN_REPEAT_EN
      r_gap     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if ((r_state != IDLE) && abort) begin
        r_state   <= IDLE;
        r_exttrig <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_accept) begin
            r_width <= w_width_in;
`ifdef TRIGGER_PULSE_GEN_REPEAT_EN
            r_gap   <= (gap == '0) ? WIDTH_W'(1) : gap;
`endif
            r_busy  <= 1'b1;
            if (offset == '0) begin
              r_state   <= HIGH;
              r_exttrig <= 1'b1;
            end else begin
              r_state <= DELAY;
            end
          end
          DELAY: if (w_dly_tc) begin
            r_state   <= HIGH;
            r_exttrig <= 1'b1;
          end
          HIGH: if (w_pw_tc) begin
            r_exttrig <= 1'b0;
            if (w_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= GAP;
            end
          end
`ifdef TRIGGER_PULSE_GEN_REPEAT_EN
          GAP: if (w_pw_tc) begin
            r_state   <= HIGH;
            r_exttrig <= 1'b1;
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign exttrig_out = r_exttrig;
  assign busy        = r_busy;
  assign done        = r_done;
endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed-vector bench: per-cycle {exttrig_out,busy,done} against hand-built patterns.
module tb_trigger_pulse_gen;
  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] offset;
  logic [15:0] width, gap;
  logic [7:0]  count;
  logic        exttrig_out, busy, done;
  logic        r_s1 = 1'b0, r_s2 = 1'b0;
  int          n_vec = 0, n_bad = 0;

  trigger_pulse_gen dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .offset(offset), .width(width), .gap(gap), .count(count),
    .exttrig_out(exttrig_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Two-flop resynchroniser on the loopback path.
  always @(posedge clk) begin
    r_s1 <= exttrig_out;
    r_s2 <= r_s1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Start is driven just after edge k; bit c of each pattern is the value after edge k+c.
  task automatic run(input string name, input logic [31:0] off, input logic [15:0] w,
                     input logic [15:0] g, input logic [7:0] cn,
                     input int stray_c, input int abort_c, input int rst_c,
                     input logic [31:0] et, input logic [31:0] eb, input logic [31:0] ed,
                     input logic [31:0] es);
    @(posedge clk); #1;
    offset = off; width = w; gap = g; count = cn; start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      start = (c == stray_c);
      abort = (c == abort_c);
      reset = (c == rst_c);
      // Scramble the parameter ports except when a stray start is being offered.
      offset = (c == stray_c) ? off : off + 32'd7;
      width  = (c == stray_c) ? w : w + 16'd3;
      gap    = (c == stray_c) ? g : g + 16'd2;
      count  = (c == stray_c) ? cn : cn + 8'd4;
      @(negedge clk);
      chk($sformatf("%s c%0d", name, c), {29'd0, exttrig_out, busy, done},
          {29'd0, et[c], eb[c], ed[c]});
      chk($sformatf("%s sync c%0d", name, c), {31'd0, r_s2}, {31'd0, es[c]});
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    offset = '0; width = '0; gap = '0; count = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset", {29'd0, exttrig_out, busy, done}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle %0d", i), {29'd0, exttrig_out, busy, done}, 32'd0);
    end

    // start and abort together in IDLE: start must be dropped.
    @(posedge clk); #1; offset = 32'd0; width = 16'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start+abort", {29'd0, exttrig_out, busy, done}, 32'd0);
    @(negedge clk);
    chk("start+abort+1", {29'd0, exttrig_out, busy, done}, 32'd0);

    run("off0w1", 32'd0, 16'd1, 16'd1, 8'd1, 0, 0, 0,
        rng(1,1), rng(1,1), rng(2,2), rng(3,3));
    // Restart offered on the done edge: sampled on the next edge.
    t = rng(1,1) | rng(3,3);
    run("b2b", 32'd0, 16'd1, 16'd1, 8'd1, 2, 0, 0,
        t, t, rng(2,2) | rng(4,4), rng(3,3) | rng(5,5));
    run("off10w5", 32'd10, 16'd5, 16'd1, 8'd1, 0, 0, 0,
        rng(11,15), rng(1,15), rng(16,16), rng(13,17));
`ifdef TRIGGER_PULSE_GEN_REPEAT_EN
    t = rng(3,5) | rng(10,12) | rng(17,19);
    run("train", 32'd2, 16'd3, 16'd4, 8'd3, 8, 0, 0,
        t, rng(1,19), rng(20,20), t << 2);
    t = rng(3,5) | rng(10,10);
    run("abort", 32'd2, 16'd3, 16'd4, 8'd3, 0, 10, 0,
        t, rng(1,10), 32'd0, t << 2);
    run("gap0", 32'd0, 16'd1, 16'd0, 8'd2, 0, 0, 0,
        rng(1,1) | rng(3,3), rng(1,3), rng(4,4), rng(3,3) | rng(5,5));
`else
    run("single", 32'd2, 16'd3, 16'd4, 8'd3, 4, 0, 0,
        rng(3,5), rng(1,5), rng(6,6), rng(5,7));
    run("abort", 32'd2, 16'd3, 16'd4, 8'd3, 0, 3, 0,
        rng(3,3), rng(1,3), 32'd0, rng(5,5));
`endif
    run("fresh", 32'd1, 16'd2, 16'd1, 8'd1, 0, 0, 0,
        rng(2,3), rng(1,3), rng(4,4), rng(4,5));
    run("rstmid", 32'd2, 16'd5, 16'd1, 8'd1, 0, 0, 4,
        rng(3,4), rng(1,4), 32'd0, rng(5,6));
    run("clamp", 32'd1, 16'd0, 16'd0, 8'd0, 0, 0, 0,
        rng(2,2), rng(1,2), rng(3,3), rng(4,4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
